image_write: RTL and testbench

Frame sink for the RGB pixel stream (VSYNC/HSYNC/DE/DATA_R/G/B) produced by the image source block. It samples the incoming pixels, assigns each a BMP bottom-up pixel address, and buffers them in a small FIFO. A ready/valid write port then drains them to an external frame memory. It also reports frame completion, a byte checksum, and sticky protocol errors.

---
 rtl/image_write_pkg.sv | 20 ++
 rtl/image_write_pixel_fifo.sv | 61 ++++++
 rtl/image_write.sv | 167 ++++++++++++++++
 tb/tb_image_write.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_write_pkg.sv
// Shared definitions for the image source/sink pair: frame geometry defaults,
// sink FSM encoding and the address-width helper.
package image_pkg;

  localparam int unsigned DEF_WIDTH  = 768;
  localparam int unsigned DEF_HEIGHT = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bits needed to index 'count' items; never less than one.
  function automatic int unsigned addr_width(input int unsigned count);
    return (count <= 32'd1) ? 32'd1 : $clog2(count);
  endfunction

endpackage

// File: rtl/image_write_pixel_fifo.sv
// Show-ahead synchronous FIFO holding {addr, R, G, B} write entries.
// Pointers carry an extra MSB so full and empty are told apart without a counter.
module pixel_fifo #(
  parameter int unsigned DATA_W = 27,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              single
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PW:0]       wr_ptr_r;
  logic [PW:0]       rd_ptr_r;
  logic [PW:0]       count_s;
  logic              do_push_s;
  logic              do_pop_s;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign count_s = wr_ptr_r - rd_ptr_r;
  assign single  = (count_s == PTR_ONE);

  // A pop frees the slot the push writes, so a full FIFO still accepts it.
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  assign rdata = empty ? {DATA_W{1'b0}} : mem_r[rd_ptr_r[PW-1:0]];

  // Entry storage; contents are only observable through a valid read pointer.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[PW-1:0]] <= wdata;
    end
  end

  // Read/write pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/image_write.sv
// Frame sink: samples the RGB stream, maps pixels to BMP bottom-up addresses,
// buffers them and drains them over a ready/valid port; reports sum and errors.
module image_write
  import image_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned HEIGHT     = DEF_HEIGHT,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = addr_width(WIDTH * HEIGHT)
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic              DE,
  input  logic [7:0]        DATA_R,
  input  logic [7:0]        DATA_G,
  input  logic [7:0]        DATA_B,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [23:0]       m_data,
  output logic              frame_done,
  output logic [31:0]       frame_sum,
  output logic              line_err,
  output logic              frame_err,
  output logic              overflow
);

  localparam int unsigned CW     = addr_width(WIDTH);
  localparam int unsigned RW     = addr_width(HEIGHT);
  localparam int unsigned AW1    = ADDR_W + 1;
  localparam int unsigned DATA_W = ADDR_W + 24;

  state_t            state_r;
  logic              vsync_d_r;
  logic [RW-1:0]     row_r;
  logic [CW-1:0]     col_r;
  logic [31:0]       sum_r;

  logic              vsync_rise_s;
  logic              push_s;
  logic              pop_s;
  logic              ovf_s;
  logic              col_last_s;
  logic              row_last_s;
  logic [31:0]       pix_sum_s;
  logic [AW1-1:0]    line_idx_s;
  logic [AW1-1:0]    addr_full_s;
  logic [ADDR_W-1:0] pix_addr_s;
  logic [DATA_W-1:0] fifo_wdata_s;
  logic [DATA_W-1:0] fifo_rdata_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_single_s;

  assign vsync_rise_s = VSYNC && !vsync_d_r;
  assign col_last_s   = (col_r == CW'(WIDTH - 1));
  assign row_last_s   = (row_r == RW'(HEIGHT - 1));
  assign pix_sum_s    = 32'(DATA_R) + 32'(DATA_G) + 32'(DATA_B);

  // First stream line lands on the last memory line (bottom-up bitmap).
  assign line_idx_s   = AW1'(HEIGHT - 1) - AW1'(row_r);
  assign addr_full_s  = AW1'(WIDTH) * line_idx_s + AW1'(col_r);
  assign pix_addr_s   = ADDR_W'(addr_full_s);
  assign fifo_wdata_s = {pix_addr_s, DATA_R, DATA_G, DATA_B};

  // A frame-start edge takes priority over a pixel in the same cycle.
  assign push_s = (state_r == ST_FRAME) && DE && !vsync_rise_s;
  assign pop_s  = m_valid && m_ready;
  assign ovf_s  = push_s && fifo_full_s && !pop_s;

  assign m_valid = !fifo_empty_s;
  assign m_addr  = fifo_rdata_s[DATA_W-1:24];
  assign m_data  = fifo_rdata_s[23:0];

  pixel_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk    (HCLK),
    .rst_n  (HRESETn),
    .push   (push_s),
    .wdata  (fifo_wdata_s),
    .pop    (pop_s),
    .rdata  (fifo_rdata_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .single (fifo_single_s)
  );

  // Frame FSM with row/col counters, checksum and sticky error flags.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r    <= ST_IDLE;
      vsync_d_r  <= 1'b0;
      row_r      <= {RW{1'b0}};
      col_r      <= {CW{1'b0}};
      sum_r      <= 32'd0;
      frame_done <= 1'b0;
      frame_sum  <= 32'd0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      vsync_d_r  <= VSYNC;
      frame_done <= 1'b0;
      if (ovf_s) begin
        overflow <= 1'b1;
      end
      if (vsync_rise_s) begin
        row_r     <= {RW{1'b0}};
        col_r     <= {CW{1'b0}};
        sum_r     <= 32'd0;
        line_err  <= 1'b0;
        overflow  <= 1'b0;
        frame_err <= (state_r == ST_FRAME) || (state_r == ST_DRAIN);
        state_r   <= ST_FRAME;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_FRAME: begin
            if (DE) begin
              sum_r <= sum_r + pix_sum_s;
              if (col_last_s) begin
                col_r <= {CW{1'b0}};
                if (row_last_s) begin
                  state_r <= ST_DRAIN;
                end else begin
                  row_r <= row_r + RW'(1);
                end
              end else begin
                col_r <= col_r + CW'(1);
              end
            end else if (HSYNC && (col_r != {CW{1'b0}})) begin
              // Short line: close it; a short last line ends the frame early.
              line_err <= 1'b1;
              col_r    <= {CW{1'b0}};
              if (row_last_s) begin
                frame_err <= 1'b1;
                state_r   <= ST_DRAIN;
              end else begin
                row_r <= row_r + RW'(1);
              end
            end
          end
          ST_DRAIN: begin
            if (fifo_empty_s || (fifo_single_s && pop_s)) begin
              frame_done <= 1'b1;
              frame_sum  <= sum_r;
              state_r    <= ST_DONE;
            end
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_image_write.sv
// Directed bench for image_write with a 4x2 frame and a 4-entry FIFO.
module tb_image_write;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int D  = 4;
  localparam int AW = 3;

  logic          HCLK    = 1'b0;
  logic          HRESETn = 1'b0;
  logic          VSYNC   = 1'b0;
  logic          HSYNC   = 1'b0;
  logic          DE      = 1'b0;
  logic [7:0]    DATA_R  = 8'd0;
  logic [7:0]    DATA_G  = 8'd0;
  logic [7:0]    DATA_B  = 8'd0;
  logic          m_ready = 1'b0;
  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic [23:0]   m_data;
  logic          frame_done;
  logic [31:0]   frame_sum;
  logic          line_err;
  logic          frame_err;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [AW+23:0] cap_q [$];

  image_write #(
    .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D), .ADDR_W(AW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC), .DE(DE),
    .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .frame_done(frame_done), .frame_sum(frame_sum),
    .line_err(line_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 HCLK = ~HCLK;

  // Record every accepted memory write and every frame_done cycle.
  always @(posedge HCLK) begin
    if (HRESETn && m_valid && m_ready) cap_q.push_back({m_addr, m_data});
    if (HRESETn && frame_done) done_cnt++;
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic pix(input logic [7:0] p);
    DATA_R = p; DATA_G = p; DATA_B = p; DE = 1'b1;
    tick();
    DE = 1'b0;
  endtask

  task automatic hsync_pulse();
    HSYNC = 1'b1;
    tick();
    HSYNC = 1'b0;
  endtask

  task automatic start_frame();
    VSYNC = 1'b1;
    tick();
    VSYNC = 1'b0;
    hsync_pulse();
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    tick(); tick();
    n_checks++;
    if ({m_valid, frame_done, line_err, frame_err, overflow} !== 5'b00000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b want 00000", {m_valid, frame_done, line_err, frame_err, overflow});
    end
    n_checks++;
    if ({frame_sum, m_addr, m_data} !== {32'd0, 3'd0, 24'd0}) begin
      n_errors++;
      $display("FAIL reset_values: sum %0d addr %0d data %h want 0 0 0", frame_sum, m_addr, m_data);
    end
    HRESETn = 1'b1;
    tick();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release_valid: got %b want 0", m_valid);
    end
  endtask

  task automatic test_nominal();
    logic [2:0] ea [8];
    ea = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
    cap_q.delete(); done_cnt = 0; m_ready = 1'b1;
    start_frame();
    pix(8'd0);
    n_checks++;
    if ({m_valid, m_addr, m_data} !== {1'b1, 3'd4, 24'h000000}) begin
      n_errors++;
      $display("FAIL nom_first_latency: got v=%b a=%0d d=%h want v=1 a=4 d=000000", m_valid, m_addr, m_data);
    end
    for (int p = 1; p < 4; p++) pix(8'(p));
    hsync_pulse();
    for (int p = 4; p < 8; p++) pix(8'(p));
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL nom_done_early: got %b want 0", frame_done);
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_errors++;
      $display("FAIL nom_done_timing: got %b want 1", frame_done);
    end
    n_checks++;
    if (frame_sum !== 32'd84) begin
      n_errors++;
      $display("FAIL nom_sum: got %0d want 84", frame_sum);
    end
    n_checks++;
    if ({line_err, frame_err, overflow} !== 3'b000) begin
      n_errors++;
      $display("FAIL nom_errs: got %b want 000", {line_err, frame_err, overflow});
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL nom_done_pulse: got %b want 0", frame_done);
    end
    tick(); tick();
    n_checks++;
    if (done_cnt != 1) begin
      n_errors++;
      $display("FAIL nom_done_count: got %0d want 1", done_cnt);
    end
    n_checks++;
    if (cap_q.size() != 8) begin
      n_errors++;
      $display("FAIL nom_write_count: got %0d want 8", cap_q.size());
    end
    for (int i = 0; i < 8 && i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== {ea[i], {3{8'(i)}}}) begin
        n_errors++;
        $display("FAIL nom_write[%0d]: got %h want %h", i, cap_q[i], {ea[i], {3{8'(i)}}});
      end
    end
  endtask

  task automatic test_backpressure_overflow();
    logic [2:0] ea [7];
    logic [7:0] ep [7];
    ea = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3};
    ep = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd15, 8'd16, 8'd17};
    cap_q.delete(); done_cnt = 0; m_ready = 1'b0;
    start_frame();
    for (int p = 10; p < 14; p++) pix(8'(p));
    n_checks++;
    if ({overflow, m_valid, m_addr, m_data} !== {1'b0, 1'b1, 3'd4, 24'h0a0a0a}) begin
      n_errors++;
      $display("FAIL bp_held: got ovf=%b v=%b a=%0d d=%h want 0 1 4 0a0a0a", overflow, m_valid, m_addr, m_data);
    end
    pix(8'd14);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_overflow: got %b want 1", overflow);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    for (int p = 15; p < 18; p++) pix(8'(p));
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame_done) break;
    end
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_done: got %b want 1 (timeout)", frame_done);
    end
    n_checks++;
    if ({overflow, frame_sum} !== {1'b1, 32'd324}) begin
      n_errors++;
      $display("FAIL bp_sum_ovf: got ovf=%b sum=%0d want 1 324", overflow, frame_sum);
    end
    n_checks++;
    if (cap_q.size() != 7) begin
      n_errors++;
      $display("FAIL bp_write_count: got %0d want 7", cap_q.size());
    end
    for (int i = 0; i < 7 && i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== {ea[i], {3{ep[i]}}}) begin
        n_errors++;
        $display("FAIL bp_write[%0d]: got %h want %h", i, cap_q[i], {ea[i], {3{ep[i]}}});
      end
    end
    tick(); tick();
  endtask

  task automatic test_full_push_pop();
    logic [2:0] ea [8];
    ea = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
    cap_q.delete(); done_cnt = 0; m_ready = 1'b0;
    start_frame();
    for (int p = 20; p < 24; p++) pix(8'(p));
    m_ready = 1'b1;
    for (int p = 24; p < 28; p++) pix(8'(p));
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL fpp_overflow: got %b want 0", overflow);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame_done) break;
    end
    n_checks++;
    if ({frame_done, frame_sum} !== {1'b1, 32'd564}) begin
      n_errors++;
      $display("FAIL fpp_done_sum: got done=%b sum=%0d want 1 564", frame_done, frame_sum);
    end
    n_checks++;
    if (cap_q.size() != 8) begin
      n_errors++;
      $display("FAIL fpp_write_count: got %0d want 8", cap_q.size());
    end
    for (int i = 0; i < 8 && i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== {ea[i], {3{8'(20 + i)}}}) begin
        n_errors++;
        $display("FAIL fpp_write[%0d]: got %h want %h", i, cap_q[i], {ea[i], {3{8'(20 + i)}}});
      end
    end
    tick(); tick();
  endtask

  task automatic test_short_line();
    logic [2:0] ea [7];
    ea = '{3'd4, 3'd5, 3'd6, 3'd0, 3'd1, 3'd2, 3'd3};
    cap_q.delete(); done_cnt = 0; m_ready = 1'b1;
    start_frame();
    for (int p = 30; p < 33; p++) pix(8'(p));
    hsync_pulse();
    n_checks++;
    if (line_err !== 1'b1) begin
      n_errors++;
      $display("FAIL sl_line_err: got %b want 1", line_err);
    end
    for (int p = 33; p < 36; p++) pix(8'(p));
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (done_cnt != 0) begin
      n_errors++;
      $display("FAIL sl_early_done: got %0d want 0", done_cnt);
    end
    pix(8'd36);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame_done) break;
    end
    n_checks++;
    if ({frame_done, line_err, frame_err, frame_sum} !== {1'b1, 1'b1, 1'b0, 32'd693}) begin
      n_errors++;
      $display("FAIL sl_done: got done=%b le=%b fe=%b sum=%0d want 1 1 0 693", frame_done, line_err, frame_err, frame_sum);
    end
    n_checks++;
    if (cap_q.size() != 7) begin
      n_errors++;
      $display("FAIL sl_write_count: got %0d want 7", cap_q.size());
    end
    for (int i = 0; i < 7 && i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== {ea[i], {3{8'(30 + i)}}}) begin
        n_errors++;
        $display("FAIL sl_write[%0d]: got %h want %h", i, cap_q[i], {ea[i], {3{8'(30 + i)}}});
      end
    end
    tick(); tick();
  endtask

  task automatic test_vsync_restart();
    logic [2:0] ea [13];
    logic [7:0] ep [13];
    ea = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
    ep = '{8'd40, 8'd41, 8'd42, 8'd43, 8'd44, 8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56, 8'd57};
    cap_q.delete(); done_cnt = 0; m_ready = 1'b1;
    start_frame();
    for (int p = 40; p < 45; p++) pix(8'(p));
    VSYNC = 1'b1;
    tick();
    VSYNC = 1'b0;
    n_checks++;
    if ({frame_err, frame_done} !== 2'b10) begin
      n_errors++;
      $display("FAIL vr_frame_err: got fe=%b done=%b want 1 0", frame_err, frame_done);
    end
    hsync_pulse();
    for (int p = 50; p < 54; p++) pix(8'(p));
    hsync_pulse();
    for (int p = 54; p < 58; p++) pix(8'(p));
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame_done) break;
    end
    n_checks++;
    if ({frame_done, frame_err, line_err, frame_sum} !== {1'b1, 1'b1, 1'b0, 32'd1284}) begin
      n_errors++;
      $display("FAIL vr_done: got done=%b fe=%b le=%b sum=%0d want 1 1 0 1284", frame_done, frame_err, line_err, frame_sum);
    end
    n_checks++;
    if (cap_q.size() != 13) begin
      n_errors++;
      $display("FAIL vr_write_count: got %0d want 13", cap_q.size());
    end
    for (int i = 0; i < 13 && i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== {ea[i], {3{ep[i]}}}) begin
        n_errors++;
        $display("FAIL vr_write[%0d]: got %h want %h", i, cap_q[i], {ea[i], {3{ep[i]}}});
      end
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] ea [8];
    ea = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
    m_ready = 1'b0;
    start_frame();
    for (int p = 70; p < 73; p++) pix(8'(p));
    hsync_pulse();
    #3;
    HRESETn = 1'b0;
    #1;
    n_checks++;
    if ({m_valid, line_err, frame_done, frame_sum, m_addr, m_data} !== {1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 24'd0}) begin
      n_errors++;
      $display("FAIL rm_async: got v=%b le=%b done=%b sum=%0d a=%0d d=%h want all 0", m_valid, line_err, frame_done, frame_sum, m_addr, m_data);
    end
    tick();
    HRESETn = 1'b1;
    tick();
    cap_q.delete(); done_cnt = 0; m_ready = 1'b1;
    start_frame();
    for (int p = 60; p < 64; p++) pix(8'(p));
    hsync_pulse();
    for (int p = 64; p < 68; p++) pix(8'(p));
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame_done) break;
    end
    n_checks++;
    if ({frame_done, line_err, frame_err, overflow, frame_sum} !== {1'b1, 3'b000, 32'd1524}) begin
      n_errors++;
      $display("FAIL rm_clean_frame: got done=%b errs=%b sum=%0d want 1 000 1524", frame_done, {line_err, frame_err, overflow}, frame_sum);
    end
    n_checks++;
    if (cap_q.size() != 8) begin
      n_errors++;
      $display("FAIL rm_write_count: got %0d want 8", cap_q.size());
    end
    for (int i = 0; i < 8 && i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== {ea[i], {3{8'(60 + i)}}}) begin
        n_errors++;
        $display("FAIL rm_write[%0d]: got %h want %h", i, cap_q[i], {ea[i], {3{8'(60 + i)}}});
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure_overflow();
    test_full_push_pop();
    test_short_line();
    test_vsync_restart();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
